// File: rtl/pipe_ctrl_pkg.sv
// Shared types and reset constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;
   localparam int REG_W        = 4;
   localparam int FLUSH_CNT_W  = 2;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam state_t                 RST_STATE       = RUN;
   localparam logic                   RST_BRANCH_PEND = 1'b0;
   localparam logic [FLUSH_CNT_W-1:0] RST_FLUSH_CNT   = '0;
endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard term. With FORWARD_EN defined only load-use stalls;
// otherwise any EX/MEM write-back to an ID source register stalls.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   input  logic             id_valid,
   input  logic             exe_wb_en,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_mem_read,
   input  logic             mem_wb_en,
   input  logic [REG_W-1:0] mem_dest,
   output logic             hazard
);

`ifdef FORWARD_EN
   // MEM-stage results are forwarded, so they never stall.
   logic unused_mem;
   assign unused_mem = mem_wb_en ^ (^mem_dest);

   assign hazard = id_valid & exe_wb_en & exe_mem_read &
                   ((exe_dest == src1) | (two_src & (exe_dest == src2)));
`else
   logic unused_ld;
   logic hit_src1;
   logic hit_src2;
   assign unused_ld = exe_mem_read;

   assign hit_src1 = (exe_wb_en & (exe_dest == src1)) | (mem_wb_en & (mem_dest == src1));
   assign hit_src2 = (exe_wb_en & (exe_dest == src2)) | (mem_wb_en & (mem_dest == src2));
   assign hazard   = id_valid & (hit_src1 | (two_src & hit_src2));
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush sequencing for the 5-stage core plus a saturating stall counter.
// Hazard rules selected by FORWARD_EN (see hazard_detect).
//
// state    | meaning
// RUN      | normal flow; branch flush and hazard stalls are combinational
// MEM_WAIT | data memory busy; front and back frozen, branch remembered
// FLUSH    | remaining IF/ID squash cycles after a taken branch
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   input  logic             id_valid,
   input  logic             exe_wb_en,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_mem_read,
   input  logic             mem_wb_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             if_freeze,
   output logic             id_flush,
   output logic             id_bubble,
   output logic             back_freeze,
   output logic             hazard,
   output logic [CNT_W-1:0] stall_cnt
);

   // The branch cycle in RUN/FLUSH is already the first squash cycle.
   localparam bit                     MULTI_FLUSH = (FLUSH_CYCLES > 1);
   localparam logic [FLUSH_CNT_W-1:0] FC_FULL     = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [FLUSH_CNT_W-1:0] FC_REST     = MULTI_FLUSH ? FLUSH_CNT_W'(FLUSH_CYCLES - 2) : '0;

   state_t                 state_q, state_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic                   branch_pend_q, branch_pend_d;
   logic                   hz_raw;
   logic                   mem_stall;

   assign mem_stall = mem_req & ~mem_ready;

   hazard_detect u_hazard_detect (
      .src1         (src1),
      .src2         (src2),
      .two_src      (two_src),
      .id_valid     (id_valid),
      .exe_wb_en    (exe_wb_en),
      .exe_dest     (exe_dest),
      .exe_mem_read (exe_mem_read),
      .mem_wb_en    (mem_wb_en),
      .mem_dest     (mem_dest),
      .hazard       (hz_raw)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= RST_STATE;
         flush_cnt_q   <= RST_FLUSH_CNT;
         branch_pend_q <= RST_BRANCH_PEND;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         branch_pend_q <= branch_pend_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      branch_pend_d = branch_pend_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d       = MEM_WAIT;
               branch_pend_d = branch_taken;
            end else if (branch_taken) begin
               state_d     = MULTI_FLUSH ? FLUSH : RUN;
               flush_cnt_d = FC_REST;
            end
         end
         MEM_WAIT: begin
            if (branch_taken) branch_pend_d = 1'b1;
            if (mem_ready) begin
               branch_pend_d = 1'b0;
               if (branch_pend_q | branch_taken) begin
                  state_d     = FLUSH;
                  flush_cnt_d = FC_FULL;
               end else begin
                  state_d = RUN;
               end
            end
         end
         FLUSH: begin
            // An interrupted flush is replayed in full once memory returns.
            if (mem_stall) begin
               state_d       = MEM_WAIT;
               branch_pend_d = 1'b1;
            end else if (branch_taken) begin
               state_d     = MULTI_FLUSH ? FLUSH : RUN;
               flush_cnt_d = FC_REST;
            end else if (flush_cnt_q == '0) begin
               state_d = RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      if_freeze   = 1'b0;
      id_flush    = 1'b0;
      id_bubble   = 1'b0;
      back_freeze = 1'b0;
      hazard      = rst & hz_raw;
      if (rst) begin
         case (state_q)
            RUN: begin
               if (mem_stall) begin
                  if_freeze   = 1'b1;
                  back_freeze = 1'b1;
               end else if (branch_taken) begin
                  id_flush = 1'b1;
               end else begin
                  if_freeze = hz_raw;
                  id_bubble = hz_raw;
               end
            end
            MEM_WAIT: begin
               if_freeze   = 1'b1;
               back_freeze = ~mem_ready;
            end
            FLUSH: begin
               if (mem_stall) begin
                  if_freeze   = 1'b1;
                  back_freeze = 1'b1;
               end else begin
                  id_flush = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (if_freeze && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors, a per-cycle behavioural model
// and literal spot checks. Builds with or without FORWARD_EN.
module tb_pipe_hazard_ctrl;
   localparam int FC = 2;
   localparam int CW = 4;
`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    src1, src2, exe_dest, mem_dest;
   logic          two_src, id_valid, exe_wb_en, exe_mem_read, mem_wb_en;
   logic          branch_taken, mem_req, mem_ready;
   logic          if_freeze, id_flush, id_bubble, back_freeze, hazard;
   logic [CW-1:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
      .id_valid(id_valid), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
      .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .if_freeze(if_freeze), .id_flush(id_flush), .id_bubble(id_bubble),
      .back_freeze(back_freeze), .hazard(hazard), .stall_cnt(stall_cnt)
   );

   task automatic check1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic checkc(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: waiting on memory, a remembered branch, squash cycles still owed.
   bit m_wait = 1'b0;
   bit m_pend = 1'b0;
   int m_left = 0;
   int m_cnt  = 0;
   logic e_hz, e_if, e_flush, e_bub, e_back;
   logic [15:0] busy;

   always_comb begin
      busy = '0;
      if (exe_wb_en && (!FWD || exe_mem_read)) busy[exe_dest] = 1'b1;
      if (!FWD && mem_wb_en) busy[mem_dest] = 1'b1;
      e_hz    = 1'b0;
      e_if    = 1'b0;
      e_flush = 1'b0;
      e_bub   = 1'b0;
      e_back  = 1'b0;
      if (rst === 1'b1) begin
         e_hz = id_valid && (busy[src1] || (two_src && busy[src2]));
         if (m_wait) begin
            e_if   = 1'b1;
            e_back = !mem_ready;
         end else if (mem_req && !mem_ready) begin
            e_if   = 1'b1;
            e_back = 1'b1;
         end else if (branch_taken || m_left > 0) begin
            e_flush = 1'b1;
         end else begin
            e_if  = e_hz;
            e_bub = e_hz;
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_wait <= 1'b0; m_pend <= 1'b0; m_left <= 0; m_cnt <= 0;
      end else begin
         if (e_if && m_cnt < (2**CW - 1)) m_cnt <= m_cnt + 1;
         if (m_wait) begin
            if (mem_ready) begin
               m_wait <= 1'b0;
               m_pend <= 1'b0;
               m_left <= (m_pend || branch_taken) ? FC : 0;
            end else if (branch_taken) begin
               m_pend <= 1'b1;
            end
         end else if (mem_req && !mem_ready) begin
            m_wait <= 1'b1;
            m_pend <= branch_taken || (m_left > 0);
            m_left <= 0;
         end else if (branch_taken) begin
            m_left <= FC - 1;
         end else if (m_left > 0) begin
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge clk) begin
      check1("hazard", hazard, e_hz);
      check1("if_freeze", if_freeze, e_if);
      check1("id_flush", id_flush, e_flush);
      check1("id_bubble", id_bubble, e_bub);
      check1("back_freeze", back_freeze, e_back);
      checkc("stall_cnt", stall_cnt, CW'(m_cnt));
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic half();
      @(negedge clk); #1;
   endtask

   task automatic idle();
      src1 = 0; src2 = 0; two_src = 0; id_valid = 0; exe_wb_en = 0; exe_dest = 0;
      exe_mem_read = 0; mem_wb_en = 0; mem_dest = 0;
      branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic set_hz(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic v, input logic ew, input logic [3:0] ed,
                         input logic ld, input logic mw, input logic [3:0] md);
      src1 = s1; src2 = s2; two_src = two; id_valid = v; exe_wb_en = ew;
      exe_dest = ed; exe_mem_read = ld; mem_wb_en = mw; mem_dest = md;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      tick(); tick();
      set_hz(4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0);
      branch_taken = 1'b1;
      half();
      check1("rst_flush", id_flush, 1'b0);
      check1("rst_hazard", hazard, 1'b0);
      tick();
      idle();
      rst = 1'b1;
      half();
      checkc("post_rst_cnt", stall_cnt, 4'd0);
      tick();

      // RAW / load-use stall on src1
`ifndef FORWARD_EN
      set_hz(4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0);
      half();
      check1("t1_hazard", hazard, 1'b1);
      check1("t1_freeze", if_freeze, 1'b1);
      check1("t1_bubble", id_bubble, 1'b1);
      tick();
      set_hz(4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3);
      half();
      check1("t1_mem_freeze", if_freeze, 1'b1);
      tick();
      idle();
      half();
      checkc("t1_cnt", stall_cnt, 4'd2);
      tick();
`else
      set_hz(4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0);
      half();
      check1("t2_alu_freeze", if_freeze, 1'b0);
      tick();
      set_hz(4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0);
      half();
      check1("t2_ld_freeze", if_freeze, 1'b1);
      check1("t2_ld_bubble", id_bubble, 1'b1);
      tick();
      set_hz(4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3);
      half();
      check1("t2_mem_freeze", if_freeze, 1'b0);
      tick();
      idle();
      half();
      checkc("t2_cnt", stall_cnt, 4'd1);
      tick();
`endif

      // hazard term vectors, checked by the model
      set_hz(4'd1, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0); tick();
      set_hz(4'd1, 4'd5, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0); tick();
      set_hz(4'd6, 4'd6, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 4'd6);
      half();
      check1("no_valid_hz", hazard, 1'b0);
      tick();
      set_hz(4'd2, 4'd9, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9);
      half();
      check1("mem_src2_hz", hazard, !FWD);
      tick();
      set_hz(4'd8, 4'd0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 4'd0); tick();
      set_hz(4'd8, 4'd4, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd7); tick();
      idle(); tick();

      // branch flush, FLUSH_CYCLES=2
      branch_taken = 1'b1;
      half();
      check1("t3_flush0", id_flush, 1'b1);
      check1("t3_freeze0", if_freeze, 1'b0);
      tick();
      branch_taken = 1'b0;
      half();
      check1("t3_flush1", id_flush, 1'b1);
      check1("t3_freeze1", if_freeze, 1'b0);
      tick();
      half();
      check1("t3_flush2", id_flush, 1'b0);
      tick();

      // hazard coinciding with branch
      set_hz(4'd7, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd0);
      branch_taken = 1'b1;
      half();
      check1("t5_flush", id_flush, 1'b1);
      check1("t5_freeze", if_freeze, 1'b0);
      check1("t5_bubble", id_bubble, 1'b0);
      tick();
      branch_taken = 1'b0;
      half();
      check1("t5_flush_hz", id_flush, 1'b1);
      check1("t5_freeze_hz", if_freeze, 1'b0);
      tick();
      half();
      check1("t5_stall_after", if_freeze, 1'b1);
      tick();
      idle(); tick();

      // memory wait with branch pulse in cycle 2
      mem_req = 1'b1;
      half();
      check1("t4_back0", back_freeze, 1'b1);
      check1("t4_if0", if_freeze, 1'b1);
      tick();
      branch_taken = 1'b1;
      half();
      check1("t4_back1", back_freeze, 1'b1);
      check1("t4_noflush1", id_flush, 1'b0);
      tick();
      branch_taken = 1'b0;
      half();
      check1("t4_back2", back_freeze, 1'b1);
      tick();
      mem_ready = 1'b1;
      half();
      check1("t4_back_ready", back_freeze, 1'b0);
      check1("t4_noflush_ready", id_flush, 1'b0);
      tick();
      mem_req = 1'b0; mem_ready = 1'b0;
      half();
      check1("t4_flush_a", id_flush, 1'b1);
      check1("t4_if_a", if_freeze, 1'b0);
      tick();
      half();
      check1("t4_flush_b", id_flush, 1'b1);
      tick();
      half();
      check1("t4_flush_c", id_flush, 1'b0);
      tick();

      // memory stall interrupting a flush, then branch on the ready cycle
      branch_taken = 1'b1; tick();
      branch_taken = 1'b0; mem_req = 1'b1;
      half();
      check1("fl_mem_noflush", id_flush, 1'b0);
      tick();
      mem_ready = 1'b1; tick();
      mem_req = 1'b0; mem_ready = 1'b0;
      half();
      check1("fl_replay", id_flush, 1'b1);
      tick(); tick(); tick();
      mem_req = 1'b1; tick();
      mem_ready = 1'b1; branch_taken = 1'b1; tick();
      idle(); tick(); tick(); tick();

      // counter saturation
      set_hz(4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0);
      repeat (16) tick();
      half();
      checkc("sat_cnt", stall_cnt, 4'd15);
      tick();
      idle(); tick();

      // asynchronous reset in MEM_WAIT
      mem_req = 1'b1;
      set_hz(4'd2, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0);
      branch_taken = 1'b1;
      tick(); tick();
      half();
      #1 rst = 1'b0;
      #1;
      check1("t6_if", if_freeze, 1'b0);
      check1("t6_back", back_freeze, 1'b0);
      check1("t6_flush", id_flush, 1'b0);
      check1("t6_bubble", id_bubble, 1'b0);
      check1("t6_hazard", hazard, 1'b0);
      checkc("t6_cnt", stall_cnt, 4'd0);
      tick();
      rst = 1'b1;
      mem_req = 1'b0; branch_taken = 1'b0;
      half();
      check1("t6_run_back", back_freeze, 1'b0);
      check1("t6_run_bubble", id_bubble, 1'b1);
      checkc("t6_run_cnt", stall_cnt, 4'd0);
      tick();
      half();
      checkc("t6_cnt_after", stall_cnt, 4'd1);
      tick();
      idle(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage ARM core. It generates the freeze and flush controls for the IF/ID stage registers and the freeze control for the EX/MEM/WB stage registers. Inputs it acts on:
- RAW data hazards
- load-use hazards
- taken branches
- external data-memory wait states
It sits beside the datapath and drives the freeze/flush pins of every stage register. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_W, 4, register-index width (R0–R15)
FLUSH_CYCLES, 1, number of consecutive cycles IF/ID are flushed after a taken branch (1..3)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
src1  in  REG_W  ID-stage first source register index
src2  in  REG_W  ID-stage second source register index
two_src  in  1  ID instruction uses src2
id_valid  in  1  ID stage holds a real instruction
exe_wb_en  in  1  EX-stage instruction writes back
exe_dest  in  REG_W  EX-stage destination
exe_mem_read  in  1  EX-stage instruction is a load
mem_wb_en  in  1  MEM-stage instruction writes back
mem_dest  in  REG_W  MEM-stage destination
branch_taken  in  1  EX-stage branch resolved taken (one-cycle pulse)
mem_req  in  1  MEM stage issues a data-memory access
mem_ready  in  1  data memory completes the access this cycle
if_freeze  out  1  hold PC and IF/ID register
id_flush  out  1  clear IF/ID and ID/EX registers (insert bubbles)
id_bubble  out  1  clear ID/EX only, due to a hazard stall
back_freeze  out  1  hold EX/MEM and MEM/WB registers
hazard  out  1  combinational hazard indication
stall_cnt  out  CNT_W  saturating count of cycles with if_freeze=1

Behaviour:
Reset:
- rst=0 forces state RUN, flush_cnt=0, branch_pend=0, stall_cnt=0.
- During reset all outputs are 0.
- Reset takes effect immediately, mid-operation included.

Hazard term (combinational, from stage inputs):
- Without FORWARD_EN: hazard = id_valid & ((exe_wb_en & exe_dest==src1) | (mem_wb_en & mem_dest==src1) | two_src & (same two matches on src2)).

States:
- RUN:
  - mem_req & !mem_ready → MEM_WAIT.
  - Else branch_taken → FLUSH.
  - Else stay in RUN.
- MEM_WAIT:
  - if_freeze=1 and back_freeze=1; no flush or bubble is issued.
  - A branch_taken pulse here sets branch_pend.
  - mem_ready=1 → FLUSH if branch_pend, else RUN.
  - The access completes on the mem_ready cycle; back_freeze drops that same cycle.
- FLUSH:
  - id_flush=1 and if_freeze=0, so the PC loads the branch target.
  - On entry, flush_cnt is loaded with FLUSH_CYCLES-1.
  - Each FLUSH cycle: flush_cnt decrements; at 0 → RUN.
  - branch_pend is cleared on entry.
  - A new branch_taken inside FLUSH reloads flush_cnt.
  - mem_req & !mem_ready inside FLUSH → MEM_WAIT, with branch_pend set so the remaining flush is replayed.

Outputs in RUN:
- if_freeze = hazard & !branch_taken.
- id_bubble = same as if_freeze.
- back_freeze = 0.
- id_flush = branch_taken, a zero-latency combinational flush on the branch cycle itself; that cycle counts as the first FLUSH cycle.

Priority for simultaneous events: memory wait > branch flush > hazard stall.
- A hazard coinciding with a flush is ignored, because the instruction is being squashed.

stall_cnt:
- Increments on every cycle with if_freeze=1.
- Saturates at all-ones.

Optional Feature:
FORWARD_EN
- Defined: forwarding unit present.
  - hazard = id_valid & exe_wb_en & exe_mem_read & (exe_dest==src1 | two_src & exe_dest==src2).
  - This is a load-use hazard only, and gives exactly a one-cycle stall per load-use.
  - MEM-stage matches never stall.
- Undefined: the full RAW hazard term above. EX or MEM matches stall until the producer has left MEM, i.e. up to 2 cycles.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, FLUSH}
  - REG_W
  - the reset-state constants
- One natural sub-module: hazard_detect.
  - Purely combinational hazard term, selected by FORWARD_EN.
  - Instantiated once.
- FSM and counters stay in the top.

Test Plan:
1. Without FORWARD_EN: src1=4'd3, id_valid=1, exe_wb_en=1, exe_dest=3 → hazard=1, if_freeze=1 and id_bubble=1 that cycle. With the producer moved to MEM, a stall still occurs (2 total). stall_cnt=2.
2. With FORWARD_EN, same stimulus with exe_mem_read=0 → no stall. With exe_mem_read=1 → exactly one stall cycle; stall_cnt=1.
3. FLUSH_CYCLES=2, branch_taken pulse in RUN → id_flush=1 for 2 consecutive cycles, if_freeze=0 throughout, then RUN.
4. mem_req=1, mem_ready=0 for 3 cycles, with branch_taken pulsed in cycle 2 → if_freeze=back_freeze=1 for 3 cycles. The cycle after mem_ready, id_flush=1 for FLUSH_CYCLES.
5. Hazard and branch_taken in the same cycle → id_flush=1, if_freeze=0, id_bubble=0.
6. rst driven low mid MEM_WAIT (asynchronous, between clock edges) → all outputs 0 immediately. After release, state=RUN and stall_cnt=0.
